// File: rtl/sram_arbiter.sv
// Two-master (inst=m0, data=m1) arbiter onto a single SRAM-like slave, one transaction in flight.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority m1 over m0.
module sram_arbiter #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rstn,

    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic [1:0]        m0_size,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [31:0]       m0_wdata,
    output logic [31:0]       m0_rdata,
    output logic              m0_addr_ok,
    output logic              m0_data_ok,

    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic [1:0]        m1_size,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    output logic [31:0]       m1_rdata,
    output logic              m1_addr_ok,
    output logic              m1_data_ok,

    output logic              s_req,
    output logic              s_wr,
    output logic [1:0]        s_size,
    output logic [ADDR_W-1:0] s_addr,
    output logic [31:0]       s_wdata,
    input  logic [31:0]       s_rdata,
    input  logic              s_addr_ok,
    input  logic              s_data_ok,

    output logic              busy
);

    typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

    state_e              state_q, state_d;
    logic                grant_q;
    logic                wr_q;
    logic [1:0]          size_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;

    logic any_req;
    logic win;
    logic done;
    logic load;
    logic addr_ok_g;

    assign any_req = m0_req | m1_req;

`ifdef ARB_ROUND_ROBIN_EN
    // Index of the requester that completed most recently; 0 after reset so m1 wins first.
    logic last_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_q <= 1'b0;
        end else if (done) begin
            last_q <= grant_q;
        end
    end

    assign win = (m0_req & m1_req) ? ~last_q : m1_req;
`else
    assign win = m1_req;
`endif

    // Completion in REQ only counts when it coincides with the address handshake.
    assign done = ((state_q == StReq) & s_addr_ok & s_data_ok) |
                  ((state_q == StResp) & s_data_ok);
    assign load = any_req & ((state_q == StIdle) | done);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (any_req) state_d = StReq;
            end
            StReq: begin
                if (s_addr_ok) begin
                    if (s_data_ok) state_d = any_req ? StReq : StIdle;
                    else           state_d = StResp;
                end
            end
            StResp: begin
                if (s_data_ok) state_d = any_req ? StReq : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            grant_q <= 1'b0;
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
        end else if (load) begin
            grant_q <= win;
            wr_q    <= win ? m1_wr    : m0_wr;
            size_q  <= win ? m1_size  : m0_size;
            addr_q  <= win ? m1_addr  : m0_addr;
            wdata_q <= win ? m1_wdata : m0_wdata;
        end
    end

    always_comb begin
        addr_ok_g  = (state_q == StReq) & s_addr_ok;
        s_req      = (state_q == StReq);
        s_wr       = wr_q;
        s_size     = size_q;
        s_addr     = addr_q;
        s_wdata    = wdata_q;
        busy       = (state_q != StIdle);
        m0_addr_ok = addr_ok_g & ~grant_q;
        m1_addr_ok = addr_ok_g & grant_q;
        m0_data_ok = done & ~grant_q;
        m1_data_ok = done & grant_q;
        // Read data is zero while idle so reset clears it immediately.
        m0_rdata   = (state_q != StIdle) ? s_rdata : 32'd0;
        m1_rdata   = (state_q != StIdle) ? s_rdata : 32'd0;
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter; inputs change on the falling edge and
// outputs are sampled 1ns later, away from the rising edge.
module tb_sram_arbiter;

    localparam int unsigned ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rstn;
    logic              m0_req, m0_wr, m1_req, m1_wr;
    logic [1:0]        m0_size, m1_size;
    logic [ADDR_W-1:0] m0_addr, m1_addr;
    logic [31:0]       m0_wdata, m1_wdata, m0_rdata, m1_rdata;
    logic              m0_addr_ok, m0_data_ok, m1_addr_ok, m1_data_ok;
    logic              s_req, s_wr;
    logic [1:0]        s_size;
    logic [ADDR_W-1:0] s_addr;
    logic [31:0]       s_wdata, s_rdata;
    logic              s_addr_ok, s_data_ok;
    logic              busy;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    sram_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .m0_req     (m0_req),
        .m0_wr      (m0_wr),
        .m0_size    (m0_size),
        .m0_addr    (m0_addr),
        .m0_wdata   (m0_wdata),
        .m0_rdata   (m0_rdata),
        .m0_addr_ok (m0_addr_ok),
        .m0_data_ok (m0_data_ok),
        .m1_req     (m1_req),
        .m1_wr      (m1_wr),
        .m1_size    (m1_size),
        .m1_addr    (m1_addr),
        .m1_wdata   (m1_wdata),
        .m1_rdata   (m1_rdata),
        .m1_addr_ok (m1_addr_ok),
        .m1_data_ok (m1_data_ok),
        .s_req      (s_req),
        .s_wr       (s_wr),
        .s_size     (s_size),
        .s_addr     (s_addr),
        .s_wdata    (s_wdata),
        .s_rdata    (s_rdata),
        .s_addr_ok  (s_addr_ok),
        .s_data_ok  (s_data_ok),
        .busy       (busy)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        m0_req = 0; m0_wr = 0; m0_size = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_wr = 0; m1_size = 0; m1_addr = 0; m1_wdata = 0;
        s_rdata = 32'h1234_5678; s_addr_ok = 0; s_data_ok = 0;
        #1;
        total++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else passed++;
        total++; if (s_req !== 1'b0) $display("FAIL rst_s_req got %b want 0", s_req); else passed++;
        total++; if (s_addr !== 32'h0) $display("FAIL rst_s_addr got %h want 0", s_addr);
                 else passed++;
        total++; if (m0_rdata !== 32'h0) $display("FAIL rst_m0_rdata got %h want 0", m0_rdata);
                 else passed++;
        step(); step();
        rstn = 1'b1;
        step();
    endtask

    // Isolated m0 read: IDLE -> REQ -> RESP -> IDLE.
    task automatic test_single_read();
        m0_req = 1; m0_wr = 0; m0_size = 2; m0_addr = 32'h100;
        #1;
        total++; if (s_req !== 1'b0) $display("FAIL rd_idle_s_req got %b want 0", s_req);
                 else passed++;
        step();
        s_addr_ok = 1;
        #1;
        total++; if (s_req !== 1'b1 || s_addr !== 32'h100 || s_wr !== 1'b0 || s_size !== 2'd2)
                     $display("FAIL rd_s_fields got req=%b addr=%h wr=%b size=%0d want 1/100/0/2",
                              s_req, s_addr, s_wr, s_size);
                 else passed++;
        total++; if (m0_addr_ok !== 1'b1 || m1_addr_ok !== 1'b0)
                     $display("FAIL rd_addr_ok got m0=%b m1=%b want 1/0", m0_addr_ok, m1_addr_ok);
                 else passed++;
        step();
        m0_req = 0; s_addr_ok = 0; s_data_ok = 1; s_rdata = 32'hDEAD_BEEF;
        #1;
        total++; if (s_req !== 1'b0 || m0_addr_ok !== 1'b0)
                     $display("FAIL rd_resp_s_req got req=%b aok=%b want 0/0", s_req, m0_addr_ok);
                 else passed++;
        total++; if (m0_data_ok !== 1'b1 || m1_data_ok !== 1'b0 || m0_rdata !== 32'hDEAD_BEEF)
                     $display("FAIL rd_data_ok got m0=%b m1=%b rdata=%h want 1/0/deadbeef",
                              m0_data_ok, m1_data_ok, m0_rdata);
                 else passed++;
        step();
        s_data_ok = 0;
        #1;
        total++; if (busy !== 1'b0 || m0_data_ok !== 1'b0)
                     $display("FAIL rd_end got busy=%b dok=%b want 0/0", busy, m0_data_ok);
                 else passed++;
    endtask

    // Simultaneous requests, fixed priority: m1 write first, then m0 with no idle cycle.
    task automatic test_priority();
        step();
        m0_req = 1; m0_wr = 0; m0_addr = 32'h300;
        m1_req = 1; m1_wr = 1; m1_size = 2; m1_addr = 32'h200; m1_wdata = 32'hCAFE_F00D;
        step();
        s_addr_ok = 1;
        #1;
        total++; if (s_wr !== 1'b1 || s_addr !== 32'h200 || s_wdata !== 32'hCAFE_F00D)
                     $display("FAIL pri_m1_fields got wr=%b addr=%h wdata=%h want 1/200/cafef00d",
                              s_wr, s_addr, s_wdata);
                 else passed++;
        total++; if (m1_addr_ok !== 1'b1 || m0_addr_ok !== 1'b0)
                     $display("FAIL pri_addr_ok got m1=%b m0=%b want 1/0", m1_addr_ok, m0_addr_ok);
                 else passed++;
        step();
        m1_req = 0; s_addr_ok = 0; s_data_ok = 1;
        #1;
        total++; if (m1_data_ok !== 1'b1 || m0_data_ok !== 1'b0)
                     $display("FAIL pri_data_ok got m1=%b m0=%b want 1/0", m1_data_ok, m0_data_ok);
                 else passed++;
        step();
        s_data_ok = 0;
        #1;
        total++; if (s_req !== 1'b1 || busy !== 1'b1 || s_addr !== 32'h300 || s_wr !== 1'b0)
                     $display("FAIL pri_b2b got req=%b busy=%b addr=%h wr=%b want 1/1/300/0",
                              s_req, busy, s_addr, s_wr);
                 else passed++;
        s_addr_ok = 1;
        #1;
        total++; if (m0_addr_ok !== 1'b1) $display("FAIL pri_m0_aok got %b want 1", m0_addr_ok);
                 else passed++;
        step();
        m0_req = 0; s_addr_ok = 0; s_data_ok = 1;
        #1;
        total++; if (m0_data_ok !== 1'b1) $display("FAIL pri_m0_dok got %b want 1", m0_data_ok);
                 else passed++;
        step();
        s_data_ok = 0;
    endtask

    // Slave stalls addr_ok for 5 cycles; a stray data_ok meanwhile must be ignored.
    task automatic test_stall();
        m1_req = 1; m1_wr = 0; m1_addr = 32'h44;
        step();
        for (int i = 0; i < 5; i++) begin
            s_data_ok = (i == 2);
            #1;
            total++; if (s_req !== 1'b1 || s_addr !== 32'h44)
                         $display("FAIL stall_hold[%0d] got req=%b addr=%h want 1/44", i, s_req, s_addr);
                     else passed++;
            total++; if ((m0_addr_ok | m1_addr_ok | m0_data_ok | m1_data_ok) !== 1'b0)
                         $display("FAIL stall_ok[%0d] got aok=%b%b dok=%b%b want 0", i,
                                  m0_addr_ok, m1_addr_ok, m0_data_ok, m1_data_ok);
                     else passed++;
            step();
        end
        s_data_ok = 0; s_addr_ok = 1;
        #1;
        total++; if (m1_addr_ok !== 1'b1) $display("FAIL stall_aok got %b want 1", m1_addr_ok);
                 else passed++;
        step();
        m1_req = 0; s_addr_ok = 0; s_data_ok = 1;
        step();
        s_data_ok = 0;
    endtask

    // Both handshakes in one REQ cycle with no pending request: straight back to IDLE.
    task automatic test_both_ok();
        m0_req = 1; m0_addr = 32'h88;
        step();
        m0_req = 0; s_addr_ok = 1; s_data_ok = 1; s_rdata = 32'h5A5A_5A5A;
        #1;
        total++; if (m0_addr_ok !== 1'b1 || m0_data_ok !== 1'b1 || m0_rdata !== 32'h5A5A_5A5A)
                     $display("FAIL both_ok got aok=%b dok=%b rdata=%h want 1/1/5a5a5a5a",
                              m0_addr_ok, m0_data_ok, m0_rdata);
                 else passed++;
        step();
        s_addr_ok = 0; s_data_ok = 0;
        #1;
        total++; if (busy !== 1'b0 || s_req !== 1'b0)
                     $display("FAIL both_ok_idle got busy=%b req=%b want 0/0", busy, s_req);
                 else passed++;
    endtask

    // Reset in RESP, then a late data_ok two cycles after release.
    task automatic test_reset_mid();
        m1_req = 1; m1_wr = 1; m1_addr = 32'h400; m1_wdata = 32'h1111_2222;
        step();
        s_addr_ok = 1;
        step();
        m1_req = 0; s_addr_ok = 0;
        #1;
        total++; if (busy !== 1'b1) $display("FAIL rmid_resp got busy=%b want 1", busy); else passed++;
        rstn = 0;
        #1;
        total++; if (busy !== 1'b0 || s_req !== 1'b0 || s_wr !== 1'b0 || s_addr !== 32'h0 ||
                     s_wdata !== 32'h0 || m1_rdata !== 32'h0)
                     $display("FAIL rmid_clear got busy=%b req=%b wr=%b addr=%h wdata=%h rd=%h want 0",
                              busy, s_req, s_wr, s_addr, s_wdata, m1_rdata);
                 else passed++;
        step();
        rstn = 1;
        step(); step();
        s_data_ok = 1;
        #1;
        total++; if (m0_data_ok !== 1'b0 || m1_data_ok !== 1'b0 || busy !== 1'b0)
                     $display("FAIL rmid_late got dok=%b%b busy=%b want 0", m0_data_ok, m1_data_ok, busy);
                 else passed++;
        step();
        s_data_ok = 0;
    endtask

    // Continuous requests from both masters over 4 transactions, starting from a fresh pointer.
    task automatic test_back_to_back();
        logic exp_g;
        m0_req = 1; m0_wr = 0; m0_addr = 32'h10;
        m1_req = 1; m1_wr = 0; m1_addr = 32'h20;
        step();
        for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_g = ((k % 2) == 0);
`else
            exp_g = 1'b1;
`endif
            s_addr_ok = 1;
            #1;
            total++; if (m1_addr_ok !== exp_g || m0_addr_ok !== !exp_g ||
                         s_addr !== (exp_g ? 32'h20 : 32'h10))
                         $display("FAIL b2b_grant[%0d] got aok=%b%b addr=%h want m1=%b", k,
                                  m1_addr_ok, m0_addr_ok, s_addr, exp_g);
                     else passed++;
            step();
            s_addr_ok = 0; s_data_ok = 1;
            if (k == 3) begin
                m0_req = 0; m1_req = 0;
            end
            #1;
            total++; if (m1_data_ok !== exp_g || m0_data_ok !== !exp_g)
                         $display("FAIL b2b_done[%0d] got dok=%b%b want m1=%b", k,
                                  m1_data_ok, m0_data_ok, exp_g);
                     else passed++;
            step();
            s_data_ok = 0;
        end
        #1;
        total++; if (busy !== 1'b0) $display("FAIL b2b_idle got busy=%b want 0", busy); else passed++;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_priority();
        test_stall();
        test_both_ok();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set the address width of all *_addr ports; the data width SHALL be fixed at 32.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rstn  in  1  asynchronous active-low reset.
REQ-005 mN_req  in  1  SRAM-like request, N=0 (inst) and N=1 (data).
REQ-006 mN_wr  in  1  1=write, 0=read.
REQ-007 mN_size  in  2  0=byte, 1=half, 2=word.
REQ-008 mN_addr  in  ADDR_W  request address.
REQ-009 mN_wdata  in  32  write data.
REQ-010 mN_rdata  out  32  read data; shared copy of s_rdata.
REQ-011 mN_addr_ok  out  1  address accepted for requester N.
REQ-012 mN_data_ok  out  1  transaction complete for requester N.
REQ-013 s_req, s_wr, s_size, s_addr, s_wdata  out  1/1/2/ADDR_W/32  downstream SRAM-like request.
REQ-014 s_rdata  in  32  downstream read data.
REQ-015 s_addr_ok, s_data_ok  in  1  downstream handshakes.
REQ-016 busy  out  1  high when state is not IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, REQ and RESP, with at most one outstanding downstream transaction.
REQ-018 In IDLE, when any mN_req=1, the block SHALL select a winner, latch its wr/size/addr/wdata and its index into grant, and enter REQ on the next edge.
REQ-019 In REQ:
- s_req SHALL be 1 and carry the latched fields, held stable until s_addr_ok.
- On s_addr_ok, m[grant]_addr_ok SHALL equal 1 in the same cycle, combinationally, and the FSM SHALL enter RESP.
REQ-020 In RESP:
- s_req SHALL be 0.
- On s_data_ok, m[grant]_data_ok SHALL be 1 in the same cycle, with mN_rdata equal to s_rdata.
REQ-021 When s_data_ok occurs in RESP:
- If any mN_req=1 in that cycle, the block SHALL arbitrate, latch and enter REQ directly, giving 0 idle cycles.
- Otherwise it SHALL enter IDLE.
REQ-022 If s_addr_ok and s_data_ok are both 1 in REQ, the block SHALL assert both m[grant]_addr_ok and m[grant]_data_ok, then apply the REQ-021 rule.
REQ-023 The non-granted requester SHALL never see addr_ok or data_ok.
REQ-024 s_data_ok SHALL be ignored in IDLE, and in REQ before s_addr_ok except under REQ-022.
REQ-025 Minimum latency SHALL be: mN_req rise to s_req is 1 cycle; isolated transaction is 3 cycles with 1-cycle addr_ok and data_ok.
REQ-026 Default arbitration SHALL be fixed priority, m1 over m0; m0 may starve under continuous m1 traffic.

Reset
REQ-027 rstn=0 SHALL immediately force:
- state IDLE, grant 0, and the last-grant pointer to 0;
- s_req, s_wr, all mN_addr_ok, all mN_data_ok and busy to 0;
- s_size, s_addr, s_wdata and mN_rdata to 0.
REQ-028 Reset asserted mid-transaction SHALL abandon the transaction, and a late s_data_ok after release SHALL be ignored per REQ-024.

Configuration
REQ-029 With ARB_ROUND_ROBIN_EN defined:
- When both request simultaneously, the requester not granted last SHALL win.
- The pointer SHALL update at each s_data_ok and reset to 0, so m1 wins first.
REQ-030 Without ARB_ROUND_ROBIN_EN, fixed priority per REQ-026 SHALL apply and no pointer register SHALL exist.

Verification
REQ-031 m0 read addr 0x100; s_addr_ok and s_data_ok are 1 cycle later each; s_rdata=0xDEADBEEF -> m0_addr_ok pulses once, m0_data_ok pulses with m0_rdata=0xDEADBEEF, m1_* stays 0, busy low after 3 cycles.
REQ-032 m0 and m1 request together in fixed mode; m1 writes 0xCAFEF00D to 0x200 -> m1 served first (s_wr=1, s_wdata=0xCAFEF00D), then m0 enters REQ in the s_data_ok cycle with no IDLE.
REQ-033 ARB_ROUND_ROBIN_EN defined, both requesting continuously for 4 transactions -> grant order is m1, m0, m1, m0.
REQ-034 s_addr_ok held 0 for 5 cycles -> s_req and s_addr stay stable for all 5 cycles, and no mN_addr_ok is asserted.
REQ-035 s_addr_ok and s_data_ok are both 1 in one REQ cycle -> addr_ok and data_ok pulse together and the next state is IDLE.
REQ-036 rstn pulled low in RESP, with s_data_ok arriving 2 cycles after release -> all outputs go to 0 immediately, and the late s_data_ok produces no mN_data_ok.
